// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - serial operand staging between register bank and ALU
//
// Purpose: fetches the operand slots selected by start_mask one at a time
// through the bank's single read port (REQ/CAP pair per slot), forwarding
// writebacks that land during a slot's window, then presents the whole set
// to the ALU with a valid/ready handshake. Unselected slots keep old values.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_valid/start_ready  fetch request handshake (ready only in IDLE)
//   start_addr, start_mask   per-slot register address, per-slot refresh enable
//   rf_ren, rf_raddr         bank read strobe/address (data returns next cycle)
//   rf_rdata                 bank read data (old value on read/write collision)
//   wb_en, wb_addr, wb_data  writeback observed for forwarding
//   op_data, op_valid        operand set to ALU, op_data slot i at [i*WIDTH +: WIDTH]
//   op_ready                 ALU consumes the operand set
module operand_fetch_unit #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 2,
  parameter int AW      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [NUM_OPS*AW-1:0]    start_addr,
  input  logic [NUM_OPS-1:0]       start_mask,
  output logic                     rf_ren,
  output logic [AW-1:0]            rf_raddr,
  input  logic [WIDTH-1:0]         rf_rdata,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic [NUM_OPS*WIDTH-1:0] op_data,
  output logic                     op_valid,
  input  logic                     op_ready
);

  localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CAP   = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t                   state;
  logic [NUM_OPS*AW-1:0]    addr_q;
  logic [NUM_OPS-1:0]       mask_q;
  logic [IW-1:0]            idx;
  logic                     byp_flag;
  logic [WIDTH-1:0]         byp_data;
  logic [NUM_OPS*WIDTH-1:0] op_data_q;

  logic                     first_found;
  logic [IW-1:0]            first_idx;
  logic                     next_found;
  logic [IW-1:0]            next_idx;
  logic [AW-1:0]            cur_addr;
  logic                     wb_hit;
  logic [WIDTH-1:0]         cap_data;

  // Lowest set bit of the incoming mask picks the first slot to fetch.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (start_mask[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = IW'(i);
      end
    end
  end

  // Next set bit strictly above the slot just captured.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (mask_q[i] && (32'(i) > 32'(idx)) && !next_found) begin
        next_found = 1'b1;
        next_idx   = IW'(i);
      end
    end
  end

  assign cur_addr = addr_q[idx*AW +: AW];
  assign wb_hit   = wb_en && (wb_addr == cur_addr);

  // A writeback in the CAP cycle is newer than anything the bank returned;
  // one in the REQ cycle was missed by the bank read (old-data collision)
  // and lives in the bypass register.
  always_comb begin
    cap_data = rf_rdata;
    if (wb_hit) begin
      cap_data = wb_data;
    end else if (byp_flag) begin
      cap_data = byp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      idx       <= '0;
      byp_flag  <= 1'b0;
      byp_data  <= '0;
      op_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            addr_q <= start_addr;
            mask_q <= start_mask;
            idx    <= first_idx;
            state  <= first_found ? REQ : VALID;
          end
        end
        REQ: begin
          if (wb_hit) begin
            byp_data <= wb_data;
            byp_flag <= 1'b1;
          end
          state <= CAP;
        end
        CAP: begin
          op_data_q[idx*WIDTH +: WIDTH] <= cap_data;
          byp_flag <= 1'b0;
          if (next_found) begin
            idx   <= next_idx;
            state <= REQ;
          end else begin
            state <= VALID;
          end
        end
        VALID: begin
          if (op_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign op_valid    = (state == VALID);
  assign rf_ren      = (state == REQ);
  assign rf_raddr    = (state == REQ) ? cur_addr : '0;
  assign op_data     = op_data_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed self-checking bench for operand_fetch_unit
module tb_operand_fetch_unit;

  localparam int WIDTH   = 16;
  localparam int NUM_OPS = 2;
  localparam int AW      = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_valid;
  logic                     start_ready;
  logic [NUM_OPS*AW-1:0]    start_addr;
  logic [NUM_OPS-1:0]       start_mask;
  logic                     rf_ren;
  logic [AW-1:0]            rf_raddr;
  logic [WIDTH-1:0]         rf_rdata;
  logic                     wb_en;
  logic [AW-1:0]            wb_addr;
  logic [WIDTH-1:0]         wb_data;
  logic [NUM_OPS*WIDTH-1:0] op_data;
  logic                     op_valid;
  logic                     op_ready;

  int n_total = 0;
  int n_pass  = 0;

  logic [WIDTH-1:0] bank [0:7];

  operand_fetch_unit #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_mask(start_mask),
    .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  // Bank model: registered read returns the pre-write value on collision.
  always @(posedge clk) begin
    if (rf_ren) rf_rdata <= bank[rf_raddr];
    if (wb_en) bank[wb_addr] <= wb_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] a1, input logic [2:0] a0, input logic [1:0] m);
    start_valid = 1'b1;
    start_addr  = {a1, a0};
    start_mask  = m;
    tick();
    start_valid = 1'b0;
    start_addr  = '0;
    start_mask  = '0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 0; start_addr = '0; start_mask = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; op_ready = 0; rf_rdata = '0;
    for (int i = 0; i < 8; i++) bank[i] = '0;
    bank[1] = 16'h1111; bank[2] = 16'h2222; bank[3] = 16'h00AA; bank[4] = 16'h0004;
    #12;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_op_valid",    32'(op_valid),    32'd0);
    check("rst_op_data",     op_data,          32'h0);
    check("rst_rf_ren",      32'(rf_ren),      32'd0);
    check("rst_rf_raddr",    32'(rf_raddr),    32'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Full two-slot fetch
    op_ready = 1'b1;
    request(3'd2, 3'd1, 2'b11);
    check("t1_req0_ren",   32'(rf_ren),   32'd1);
    check("t1_req0_addr",  32'(rf_raddr), 32'd1);
    check("t1_req0_rdy",   32'(start_ready), 32'd0);
    tick();
    check("t1_cap0_ren",   32'(rf_ren),   32'd0);
    check("t1_cap0_addr",  32'(rf_raddr), 32'd0);
    tick();
    check("t1_req1_addr",  32'(rf_raddr), 32'd2);
    check("t1_partial",    op_data,       32'h0000_1111);
    tick();
    check("t1_cap1_valid", 32'(op_valid), 32'd0);
    tick();
    check("t1_valid",      32'(op_valid), 32'd1);
    check("t1_data",       op_data,       32'h2222_1111);
    tick();
    check("t1_idle_valid", 32'(op_valid), 32'd0);
    check("t1_idle_ready", 32'(start_ready), 32'd1);

    // Partial refresh of slot1 only
    request(3'd3, 3'd5, 2'b10);
    check("t2_req_addr",   32'(rf_raddr), 32'd3);
    tick();
    tick();
    check("t2_valid",      32'(op_valid), 32'd1);
    check("t2_data",       op_data,       32'h00AA_1111);
    tick();

    // Empty mask
    request(3'd1, 3'd2, 2'b00);
    check("t3_no_ren",     32'(rf_ren),   32'd0);
    check("t3_valid",      32'(op_valid), 32'd1);
    check("t3_data",       op_data,       32'h00AA_1111);
    tick();

    // Writeback during REQ goes through the bypass register
    request(3'd0, 3'd4, 2'b01);
    wb_en = 1; wb_addr = 3'd4; wb_data = 16'hBEEF;
    tick();
    wb_en = 0;
    tick();
    check("t4_req_byp",    op_data,       32'h00AA_BEEF);
    op_ready = 1'b0;
    wb_en = 1; wb_addr = 3'd4; wb_data = 16'h1234;
    tick();
    wb_en = 0;
    check("t4_valid_snap", op_data,       32'h00AA_BEEF);
    check("t4_valid_hold", 32'(op_valid), 32'd1);
    op_ready = 1'b1;
    tick();

    // Writeback during CAP wins over bank data
    request(3'd0, 3'd4, 2'b01);
    tick();
    wb_en = 1; wb_addr = 3'd4; wb_data = 16'hCAFE;
    tick();
    wb_en = 0;
    check("t5_cap_fwd",    op_data,       32'h00AA_CAFE);
    tick();

    // Back-pressure in VALID; start_valid ignored
    op_ready = 1'b0;
    request(3'd1, 3'd0, 2'b10);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0];
      start_mask  = 2'b11;
      check("t6_valid",  32'(op_valid),    32'd1);
      check("t6_ready",  32'(start_ready), 32'd0);
      check("t6_data",   op_data,          32'h1111_CAFE);
      tick();
    end
    start_valid = 0; start_mask = '0;
    op_ready = 1'b1;
    tick();
    check("t6_idle",       32'(start_ready), 32'd1);
    check("t6_no_req",     32'(rf_ren),      32'd0);

    // Reset during second CAP
    request(3'd2, 3'd1, 2'b11);
    tick(); tick(); tick();
    check("t7_pre_rst",    op_data,       32'h1111_1111);
    #1 rst = 1'b1;
    #1;
    check("t7_rst_valid",  32'(op_valid),    32'd0);
    check("t7_rst_data",   op_data,          32'h0);
    check("t7_rst_ready",  32'(start_ready), 32'd1);
    #1 rst = 1'b0;
    tick();
    request(3'd2, 3'd1, 2'b11);
    tick(); tick(); tick();
    check("t7_lat",        32'(op_valid), 32'd0);
    tick();
    check("t7_valid",      32'(op_valid), 32'd1);
    check("t7_data",       op_data,       32'h2222_1111);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
